// File: rtl/turbo_block_interleaver.sv
// turbo_block_interleaver: row/column block interleaver feeding the second RSC encoder.
//
//   Frame of K = ROWS*COLS bits is written row-major and replayed column-major
//   (output index r reads row r%ROWS, column r/ROWS) as a valid/ready bit stream.
//
//   Ports:
//     clk        system clock, rising edge
//     clr        asynchronous active-low reset (counters, state, flags; storage kept)
//     in_valid   upstream bit available
//     in_bit     systematic input bit
//     in_ready   block can accept a bit
//     out_valid  interleaved bit available
//     out_bit    interleaved bit (combinational read of current read address)
//     out_ready  downstream accepts the bit
//     out_last   out_bit is the final bit of the interleaved frame
//     frame_done one-cycle pulse after the final bit is accepted downstream
//
//   Optional build macro TURBO_INTERLEAVER_PINGPONG_EN: two storage banks so a
//   new frame can be written while the previous one drains. Without it the
//   block alternates between a FILL and a DRAIN phase on a single buffer.
module turbo_block_interleaver #(
   parameter int ROWS = 4,
   parameter int COLS = 8,
   parameter int CW   = 3,
   parameter int RW   = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic in_valid,
   input  logic in_bit,
   output logic in_ready,
   output logic out_valid,
   output logic out_bit,
   input  logic out_ready,
   output logic out_last,
   output logic frame_done
);
   localparam int K  = ROWS * COLS;
   localparam int AW = $clog2(K);

   logic [RW-1:0] wr_row, rd_row;
   logic [CW-1:0] wr_col, rd_col;
   logic [AW-1:0] wr_addr, rd_addr;
   logic          wr_acc, rd_acc, wr_end, rd_end;

   assign wr_acc   = in_valid & in_ready;
   assign rd_acc   = out_valid & out_ready;
   assign wr_end   = (wr_row == RW'(ROWS - 1)) && (wr_col == CW'(COLS - 1));
   assign rd_end   = (rd_row == RW'(ROWS - 1)) && (rd_col == CW'(COLS - 1));
   assign wr_addr  = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
   assign rd_addr  = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
   // Read counters idle at zero outside a drain, so gating with out_valid
   // keeps out_last low during reset and while filling.
   assign out_last = out_valid & rd_end;

   // Write walks columns fastest, read walks rows fastest; both clear at frame end.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wr_row <= '0;
         wr_col <= '0;
         rd_row <= '0;
         rd_col <= '0;
      end else begin
         if (wr_acc) begin
            wr_col <= (wr_col == CW'(COLS - 1)) ? '0 : wr_col + 1'b1;
            wr_row <= wr_end ? '0 : (wr_col == CW'(COLS - 1)) ? wr_row + 1'b1 : wr_row;
         end
         if (rd_acc) begin
            rd_row <= (rd_row == RW'(ROWS - 1)) ? '0 : rd_row + 1'b1;
            rd_col <= rd_end ? '0 : (rd_row == RW'(ROWS - 1)) ? rd_col + 1'b1 : rd_col;
         end
      end
   end

`ifdef TURBO_INTERLEAVER_PINGPONG_EN
   logic [K-1:0] mem [2];
   logic [1:0]   full, full_n;
   logic         wr_bank, rd_bank, wr_bank_n, rd_bank_n;

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_bank][wr_addr] <= in_bit;
   end

   assign out_bit = mem[rd_bank][rd_addr];

   // Write and read completions may land in the same cycle; they always
   // touch different banks, so both updates apply.
   always_comb begin
      full_n = full;
      if (wr_acc && wr_end) full_n[wr_bank] = 1'b1;
      if (rd_acc && rd_end) full_n[rd_bank] = 1'b0;
      wr_bank_n = wr_bank ^ (wr_acc & wr_end);
      rd_bank_n = rd_bank ^ (rd_acc & rd_end);
   end

   // Handshake flags are registered from the next-state bank view so they
   // match !full[wr_bank] / full[rd_bank] while staying low during reset.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         full       <= '0;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         full       <= full_n;
         wr_bank    <= wr_bank_n;
         rd_bank    <= rd_bank_n;
         in_ready   <= ~full_n[wr_bank_n];
         out_valid  <= full_n[rd_bank_n];
         frame_done <= rd_acc & rd_end;
      end
   end
`else
   typedef enum logic {FILL, DRAIN} state_t;

   state_t       state;
   logic [K-1:0] mem;

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_addr] <= in_bit;
   end

   assign out_bit = mem[rd_addr];

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state      <= FILL;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (state == FILL) begin
            in_ready <= ~(wr_acc & wr_end);
            if (wr_acc && wr_end) begin
               state     <= DRAIN;
               out_valid <= 1'b1;
            end
         end else if (rd_acc && rd_end) begin
            state      <= FILL;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            frame_done <= 1'b1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_turbo_block_interleaver.sv
// tb_turbo_block_interleaver: directed and random checks of the 4x8 block interleaver.
module tb_turbo_block_interleaver;
   logic clk = 1'b0, clr = 1'b0;
   logic in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, out_bit, out_last, frame_done;
   int   total = 0, bad = 0;

`ifdef TURBO_INTERLEAVER_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   turbo_block_interleaver #(.ROWS(4), .COLS(8), .CW(3), .RW(2)) dut (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready),
      .out_last(out_last), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference permutation: output index r carries input index (r%4)*8 + r/4.
   function automatic logic [31:0] perm(input logic [31:0] f);
      logic [31:0] p;
      for (int r = 0; r < 32; r++) p[r] = f[(r % 4) * 8 + r / 4];
      return p;
   endfunction

   // Called at a negedge; sends n bits of f, returns at the negedge after the last accept.
   task automatic send_frame(input logic [31:0] f, input int n, output int stalls);
      int w;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_bit   = f[i];
         w = 0;
         while (!in_ready && w < 200) begin
            stalls++;
            w++;
            @(negedge clk);
         end
         if (w >= 200) begin
            total++;
            bad++;
            $error("FAIL send_timeout observed=stuck_at_bit_%0d expected=accept", i);
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   // mode 0: out_ready=1, 1: toggles each cycle, 2: random. Returns at the
   // negedge after the final accept, where frame_done must be high.
   task automatic recv_frame(input int mode, input bit chk_ir, input string tag,
                             output logic [31:0] o, output int first_wait);
      int n = 0, cyc = 0, stab = 0, irv = 0, lastv = 0;
      bit stalled = 1'b0;
      logic sb = 1'b0, sl = 1'b0;
      o = '0;
      first_wait = -1;
      while (n < 32 && cyc < 400) begin
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
         if (chk_ir && in_ready) irv++;
         if (stalled && out_valid && (out_bit !== sb || out_last !== sl)) stab++;
         if (out_valid && out_ready) begin
            if (first_wait < 0) first_wait = cyc;
            o[n] = out_bit;
            if (out_last !== (n == 31)) lastv++;
            n++;
            stalled = 1'b0;
         end else if (out_valid) begin
            stalled = 1'b1;
            sb = out_bit;
            sl = out_last;
         end
         cyc++;
         @(negedge clk);
      end
      check({tag, "_count"}, n, 32);
      check({tag, "_stall_stable"}, stab, 0);
      check({tag, "_out_last_pos"}, lastv, 0);
      if (chk_ir) check({tag, "_in_ready_low"}, irv, 0);
      check({tag, "_frame_done"}, frame_done, 1'b1);
   endtask

   initial begin
      logic [31:0] f, o, o2;
      int s, s2, fw, fw2;

      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      clr = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);

      // Impulse A: input index 1 lands at output index 4.
      send_frame(32'h0000_0002, 32, s);
      check("latency_out_valid", out_valid, 1'b1);
      recv_frame(0, !PP, "impA", o, fw);
      check("impA_data", o, 32'h0000_0010);
      @(negedge clk);
      check("impA_done_single_pulse", frame_done, 1'b0);

      // Impulse B: input 8 -> output 1, input 31 -> output 31.
      send_frame(32'h8000_0100, 32, s);
      recv_frame(0, !PP, "impB", o, fw);
      check("impB_data", o, 32'h8000_0002);

      // Back-pressure with out_ready toggling.
      f = 32'hA5C3_0F96;
      send_frame(f, 32, s);
      recv_frame(1, !PP, "bp", o, fw);
      check("bp_data", o, perm(f));

      // Asynchronous reset mid-fill after 10 bits.
      @(negedge clk);
      send_frame(32'hFFFF_FFFF, 10, s);
      check("pre_clr_in_ready", in_ready, 1'b1);
      #2 clr = 1'b0;
      #1;
      check("clr_in_ready", in_ready, 1'b0);
      check("clr_out_valid", out_valid, 1'b0);
      check("clr_out_last", out_last, 1'b0);
      check("clr_frame_done", frame_done, 1'b0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      send_frame(32'h0000_0001, 32, s);
      recv_frame(0, !PP, "after_clr", o, fw);
      check("after_clr_data", o, 32'h0000_0001);

`ifdef TURBO_INTERLEAVER_PINGPONG_EN
      // Two frames back-to-back with full-rate input and output.
      f = 32'h1234_5678;
      o2 = 32'h9ABC_DEF0;
      fork
         begin
            send_frame(f, 32, s);
            in_valid = 1'b1;
            send_frame(o2, 32, s2);
         end
         begin
            recv_frame(0, 1'b0, "pp1", o, fw);
            check("pp1_data", o, perm(f));
            recv_frame(0, 1'b0, "pp2", o, fw2);
            check("pp2_data", o, perm(o2));
         end
      join
      check("pp2_in_stalls", s2, 0);
      check("pp2_first_wait", fw2, 0);

      // Both banks fill while the output is blocked.
      out_ready = 1'b0;
      f = 32'hDEAD_BEEF;
      o2 = 32'h0F0F_3C3C;
      send_frame(f, 32, s);
      send_frame(o2, 32, s2);
      check("pp_full_in_ready", in_ready, 1'b0);
      repeat (3) @(negedge clk);
      check("pp_full_hold_in_ready", in_ready, 1'b0);
      check("pp_full_out_valid", out_valid, 1'b1);
      recv_frame(0, 1'b0, "pp3", o, fw);
      check("pp3_data", o, perm(f));
      recv_frame(0, 1'b0, "pp4", o, fw);
      check("pp4_data", o, perm(o2));
`endif

      // Random frames with random back-pressure.
      for (int k = 0; k < 100; k++) begin
         f = $urandom;
         send_frame(f, 32, s);
         recv_frame(2, !PP, "rnd", o, fw);
         check("rnd_data", o, perm(f));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
